// File: rtl/gpu_pkg.sv
// Shared types and constants for the 2D GPU pixel datapath.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } pw_state_t;

    localparam int PIX_BYTES = 4;

endpackage

// File: rtl/pix_addr_gen.sv
// Combinational bounds check and frame-buffer byte address for one pixel.
module pix_addr_gen
    import gpu_pkg::*;
#(
    parameter int              SCREEN_W  = 640,
    parameter int              SCREEN_H  = 480,
    parameter int              XW        = 10,
    parameter int              YW        = 10,
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          in_bounds,
    output logic [AW-1:0] addr
);

    // Work at 64 bits so the multiply-add cannot overflow before truncation.
    always_comb begin
        in_bounds = (64'(x) < 64'(SCREEN_W)) && (64'(y) < 64'(SCREEN_H));
        addr      = AW'(64'(BASE_ADDR)
                        + (64'(y) * 64'(SCREEN_W) + 64'(x)) * 64'(PIX_BYTES));
    end

endmodule

// File: rtl/pixel_writer.sv
// Pixel output stage: one Avalon-MM write per offered pixel, with
// per-shape write/drop statistics latched on shape_done.
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int            SCREEN_W  = 640,
    parameter int            SCREEN_H  = 480,
    parameter int            XW        = 10,
    parameter int            YW        = 10,
    parameter int            CW        = 24,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int            CNTW      = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            data_ready,
    input  logic [XW-1:0]   pix_x,
    input  logic [YW-1:0]   pix_y,
    input  logic [CW-1:0]   pix_color,
    input  logic            shape_done,
    output logic            data_sent,
    output logic [AW-1:0]   avm_address,
    output logic            avm_write,
    output logic [31:0]     avm_writedata,
    input  logic            avm_waitrequest,
    output logic            busy,
    output logic            overrun,
    output logic [CNTW-1:0] shape_pixels,
    output logic [CNTW-1:0] shape_dropped
);

    pw_state_t       state;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   color_q;
    logic [CNTW-1:0] pix_cnt;
    logic [CNTW-1:0] drop_cnt;
    logic            in_bounds;
    logic [AW-1:0]   addr_calc;
    logic            inc_pix;
    logic            inc_drop;

    pix_addr_gen #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .XW        (XW),
        .YW        (YW),
        .AW        (AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr (
        .x         (x_q),
        .y         (y_q),
        .in_bounds (in_bounds),
        .addr      (addr_calc)
    );

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNTW'(1) : v;
    endfunction

    assign inc_pix  = (state == WRITE) && !avm_waitrequest;
    assign inc_drop = (state == CALC) && !in_bounds;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            color_q       <= '0;
            data_sent     <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            pix_cnt       <= '0;
            drop_cnt      <= '0;
            shape_pixels  <= '0;
            shape_dropped <= '0;
        end else begin
            data_sent <= 1'b0;
            if (data_ready && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: if (data_ready) begin
                    x_q     <= pix_x;
                    y_q     <= pix_y;
                    color_q <= pix_color;
                    busy    <= 1'b1;
                    state   <= CALC;
                end
                CALC: if (in_bounds) begin
                    avm_address   <= addr_calc;
                    avm_writedata <= 32'(color_q);
                    avm_write     <= 1'b1;
                    state         <= WRITE;
                end else begin
                    data_sent <= 1'b1;
                    state     <= ACK;
                end
                WRITE: if (!avm_waitrequest) begin
                    avm_write <= 1'b0;
                    data_sent <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // An increment landing on the shape_done cycle belongs to the finished shape.
            if (shape_done) begin
                shape_pixels  <= sat_inc(pix_cnt, inc_pix);
                shape_dropped <= sat_inc(drop_cnt, inc_drop);
                pix_cnt       <= '0;
                drop_cnt      <= '0;
            end else begin
                pix_cnt  <= sat_inc(pix_cnt, inc_pix);
                drop_cnt <= sat_inc(drop_cnt, inc_drop);
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed, table-driven bench for pixel_writer acting as an Avalon slave.
module tb_pixel_writer;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic            data_ready;
    logic [9:0]      pix_x;
    logic [9:0]      pix_y;
    logic [23:0]     pix_color;
    logic            shape_done;
    logic            data_sent;
    logic [31:0]     avm_address;
    logic            avm_write;
    logic [31:0]     avm_writedata;
    logic            avm_waitrequest;
    logic            busy;
    logic            overrun;
    logic [CNTW-1:0] shape_pixels;
    logic [CNTW-1:0] shape_dropped;

    int checks   = 0;
    int failures = 0;

    pixel_writer #(.CNTW(CNTW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .data_ready      (data_ready),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_color       (pix_color),
        .shape_done      (shape_done),
        .data_sent       (data_sent),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .overrun         (overrun),
        .shape_pixels    (shape_pixels),
        .shape_dropped   (shape_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] color;
        int          stall;
        bit          oob;
        logic [31:0] exp_addr;
        int          exp_ds;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Cycle k of a transaction is sampled on the negedge after the k-th posedge
    // following the data_ready pulse.
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [23:0] color,
                                 input int stall, input bit done_at_accept, input bit second_ready,
                                 output int ds_cycle, output int ds_count, output int wr_first,
                                 output int wr_count, output logic [31:0] addr,
                                 output logic [31:0] wdata, output bit stable);
        int stalls;
        ds_cycle = -1;
        ds_count = 0;
        wr_first = -1;
        wr_count = 0;
        addr     = '0;
        wdata    = '0;
        stable   = 1'b1;
        stalls   = 0;
        @(negedge clk);
        data_ready = 1'b1;
        pix_x      = x;
        pix_y      = y;
        pix_color  = color;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            data_ready = 1'b0;
            shape_done = 1'b0;
            if (cyc == 1 && second_ready) begin
                data_ready = 1'b1;
                pix_x      = 10'd5;
                pix_y      = 10'd5;
                pix_color  = 24'h123456;
            end
            if (data_sent) begin
                ds_count++;
                if (ds_cycle < 0) ds_cycle = cyc;
            end
            if (avm_write) begin
                if (wr_first < 0) begin
                    wr_first = cyc;
                    addr     = avm_address;
                    wdata    = avm_writedata;
                end else if (avm_address !== addr || avm_writedata !== wdata) begin
                    stable = 1'b0;
                end
                if (stalls < stall) begin
                    avm_waitrequest = 1'b1;
                    stalls++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wr_count++;
                    if (done_at_accept) shape_done = 1'b1;
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (ds_cycle >= 0 && cyc >= ds_cycle + 1) break;
        end
        shape_done = 1'b0;
    endtask

    task automatic pulseShapeDone();
        @(negedge clk);
        shape_done = 1'b1;
        @(negedge clk);
        shape_done = 1'b0;
    endtask

    initial begin
        int ds_cycle, ds_count, wr_first, wr_count, sent;
        logic [31:0] addr, wdata;
        bit stable;

        nreset          = 1'b0;
        data_ready      = 1'b0;
        pix_x           = '0;
        pix_y           = '0;
        pix_color       = '0;
        shape_done      = 1'b0;
        avm_waitrequest = 1'b0;

        vecs[0] = '{10'd3,   10'd2,   24'hFF0000, 0, 1'b0, 32'd5132,    3};
        vecs[1] = '{10'd639, 10'd479, 24'h00ABCD, 3, 1'b0, 32'd1228796, 6};
        vecs[2] = '{10'd0,   10'd0,   24'h000001, 1, 1'b0, 32'd0,       4};
        vecs[3] = '{10'd640, 10'd0,   24'h777777, 0, 1'b1, 32'd0,       2};
        vecs[4] = '{10'd0,   10'd480, 24'h888888, 0, 1'b1, 32'd0,       2};
        vecs[5] = '{10'd639, 10'd0,   24'hFFFFFF, 0, 1'b0, 32'd2556,    3};

        repeat (2) @(negedge clk);
        checkOutput("reset_avm_write", 64'(avm_write), 64'd0);
        checkOutput("reset_avm_address", 64'(avm_address), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_data_sent", 64'(data_sent), 64'd0);
        checkOutput("reset_shape_pixels", 64'(shape_pixels), 64'd0);
        nreset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].stall, 1'b0, 1'b0,
                          ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
            checkOutput($sformatf("v%0d_ds_cycle", i), 64'(ds_cycle), 64'(vecs[i].exp_ds));
            checkOutput($sformatf("v%0d_ds_count", i), 64'(ds_count), 64'd1);
            if (vecs[i].oob) begin
                checkOutput($sformatf("v%0d_no_write", i), 64'(wr_first < 0), 64'd1);
            end else begin
                checkOutput($sformatf("v%0d_write_cycle", i), 64'(wr_first), 64'd2);
                checkOutput($sformatf("v%0d_address", i), 64'(addr), 64'(vecs[i].exp_addr));
                checkOutput($sformatf("v%0d_writedata", i), 64'(wdata), 64'({8'h00, vecs[i].color}));
                checkOutput($sformatf("v%0d_stable", i), 64'(stable), 64'd1);
                checkOutput($sformatf("v%0d_accepts", i), 64'(wr_count), 64'd1);
            end
        end
        checkOutput("table_busy_idle", 64'(busy), 64'd0);
        checkOutput("table_no_overrun", 64'(overrun), 64'd0);
        pulseShapeDone();
        checkOutput("table_shape_pixels", 64'(shape_pixels), 64'd4);
        checkOutput("table_shape_dropped", 64'(shape_dropped), 64'd2);

        applyStimulus(10'd640, 10'd0, 24'h0, 0, 1'b0, 1'b0,
                      ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        pulseShapeDone();
        checkOutput("oob_shape_dropped", 64'(shape_dropped), 64'd1);
        checkOutput("oob_shape_pixels", 64'(shape_pixels), 64'd0);

        for (int i = 0; i < 8; i++)
            applyStimulus(10'(i), 10'd7, 24'h00FF00, 0, 1'b0, 1'b0,
                          ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        applyStimulus(10'd100, 10'd100, 24'h0000FF, 0, 1'b1, 1'b0,
                      ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        checkOutput("stats_shape_pixels", 64'(shape_pixels), 64'd9);
        checkOutput("stats_shape_dropped", 64'(shape_dropped), 64'd0);
        pulseShapeDone();
        checkOutput("stats_empty_shape", 64'(shape_pixels), 64'd0);

        // 17 writes into a 4-bit counter must stick at 15.
        for (int i = 0; i < 17; i++)
            applyStimulus(10'(i), 10'd1, 24'h010203, 0, 1'b0, 1'b0,
                          ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        pulseShapeDone();
        checkOutput("sat_shape_pixels", 64'(shape_pixels), 64'd15);

        applyStimulus(10'd10, 10'd1, 24'hABCDEF, 0, 1'b0, 1'b1,
                      ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        checkOutput("overrun_accepts", 64'(wr_count), 64'd1);
        checkOutput("overrun_address", 64'(addr), 64'd2600);
        checkOutput("overrun_ds_count", 64'(ds_count), 64'd1);
        applyStimulus(10'd1, 10'd0, 24'h1, 0, 1'b0, 1'b0,
                      ds_cycle, ds_count, wr_first, wr_count, addr, wdata, stable);
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);

        @(negedge clk);
        data_ready = 1'b1;
        pix_x      = 10'd1;
        pix_y      = 10'd1;
        pix_color  = 24'hCAFE00;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_in_write", 64'(avm_write), 64'd1);
        avm_waitrequest = 1'b1;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_avm_write", 64'(avm_write), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_address", 64'(avm_address), 64'd0);
        checkOutput("rst_mid_writedata", 64'(avm_writedata), 64'd0);
        checkOutput("rst_mid_overrun", 64'(overrun), 64'd0);
        checkOutput("rst_mid_shape_pixels", 64'(shape_pixels), 64'd0);
        checkOutput("rst_mid_shape_dropped", 64'(shape_dropped), 64'd0);
        sent = int'(data_sent);
        avm_waitrequest = 1'b0;
        nreset          = 1'b1;
        repeat (4) begin
            @(negedge clk);
            sent += int'(data_sent);
        end
        checkOutput("rst_mid_no_data_sent", 64'(sent), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Pixel output stage of the 2D GPU datapath: the responder on the `data_ready`/`data_sent` handshake that the core control unit and the primitive generators drive. For each pixel offered by the active line or arc generator, it computes the frame-buffer byte address, performs one write on an Avalon-MM master port (honouring `avm_waitrequest`), and then returns `data_sent` so the core can advance to the next pixel. It also keeps per-shape statistics that are latched on `shape_done`.

## Interface
Parameters:
- `SCREEN_W`, 640: frame width in pixels.
- `SCREEN_H`, 480: frame height in pixels.
- `XW`, 10: x coordinate width.
- `YW`, 10: y coordinate width.
- `CW`, 24: colour width, with `CW` ≤ 32.
- `AW`, 32: Avalon address width.
- `BASE_ADDR`, 32'h0000_0000: frame-buffer base byte address.
- `CNTW`, 16: statistics counter width.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `nreset`  in  1  reset. Synchronous, active-low.
- `data_ready`  in  1  one-cycle pulse from the generator: the pixel inputs are valid this cycle.
- `pix_x`  in  XW  pixel x, unsigned.
- `pix_y`  in  YW  pixel y, unsigned.
- `pix_color`  in  CW  pixel colour.
- `shape_done`  in  1  one-cycle pulse from the core at the end of a shape.
- `data_sent`  out  1  one-cycle pulse: the pixel has been written or dropped.
- `avm_address`  out  AW  byte address of the write.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  `pix_color`, zero-extended to 32 bits.
- `avm_waitrequest`  in  1  slave stall.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  sticky flag: a `data_ready` pulse arrived while `busy`. Cleared only by reset.
- `shape_pixels`  out  CNTW  pixels written during the last completed shape.
- `shape_dropped`  out  CNTW  out-of-bounds pixels dropped during the last completed shape.

## Operation
- State machine with four states: IDLE, CALC, WRITE, ACK.
- IDLE:
  - When `data_ready` is high, capture `pix_x`, `pix_y` and `pix_color` into registers, then go to CALC.
- CALC:
  - In bounds means `x < SCREEN_W` and `y < SCREEN_H`.
  - If in bounds: register `avm_address = BASE_ADDR + (y*SCREEN_W + x)*4`, computed at full width and truncated modulo 2^AW. Register `avm_writedata`. Go to WRITE.
  - If out of bounds: increment the running drop counter and go to ACK. No bus cycle is issued.
- WRITE:
  - `avm_write` = 1.
  - Address and data stay stable while `avm_waitrequest` = 1.
  - When `avm_waitrequest` = 0, the write is accepted: increment the running write counter and go to ACK.
- ACK:
  - `data_sent` = 1 for exactly one cycle, then go to IDLE.
- `shape_done`, in any state:
  - Copy the running counters into `shape_pixels` / `shape_dropped`, then clear the running counters.
  - If a counter increments in the same cycle, that increment is included in the latched value and the running counter restarts at 0.
- `data_ready` while `busy`: the pixel is ignored and `overrun` is set. The in-flight pixel is unaffected.
- Counters saturate at all-ones. They do not wrap.
- Reset, including reset in the middle of a write: on the next edge the FSM goes to IDLE and all outputs and counters go to 0. An in-progress bus write is abandoned.
- Reset value of every output: 0. This covers `avm_address`, `avm_writedata`, `avm_write`, `data_sent`, `busy`, `overrun`, `shape_pixels` and `shape_dropped`.

## Timing
- Cycle numbering: the `data_ready` pulse is at cycle 0.
- Cycle 1: CALC.
- Cycle 2: WRITE with `avm_write` = 1.
- With no stalls, `data_sent` is high at cycle 3, and the earliest next capture is at cycle 4.
- Each stall cycle (`avm_waitrequest` = 1) adds one cycle.
- Out-of-bounds pixel: `data_sent` is high at cycle 2.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `gpu_pkg`: the `pw_state_t` enum (IDLE, CALC, WRITE, ACK) and the constant `PIX_BYTES = 4`.
- Sub-module `pix_addr_gen`: purely combinational bounds check plus address multiply-add. Parameterised by `SCREEN_W`, `SCREEN_H`, `AW` and `BASE_ADDR`.

## Test plan
- Single pixel, no stall. Stimulus: (x=3, y=2, color=24'hFF0000), `avm_waitrequest` = 0. Required: at cycle 2, `avm_write` = 1, `avm_address` = 5132, `avm_writedata` = 32'h00FF0000; `data_sent` pulses at cycle 3.
- Stall. Stimulus: pixel (639, 479), `avm_waitrequest` held at 1 for 3 cycles. Required: `avm_address` = 1228796, held stable through the stall; `data_sent` pulses at cycle 6, exactly once.
- Out of bounds. Stimulus: pixel (640, 0). Required: no `avm_write`; `data_sent` at cycle 2. A following `shape_done` gives `shape_dropped` = 1, `shape_pixels` = 0.
- Statistics. Stimulus: 8 in-bounds pixels, then `shape_done` coincident with the 9th write acceptance. Required: `shape_pixels` = 9; the next `shape_done` with no pixels gives 0.
- Overrun. Stimulus: a second `data_ready` pulse at cycle 1. Required: `overrun` = 1 and stays set; only the first pixel is written; one `data_sent` pulse.
- Reset mid-write. Stimulus: `nreset` = 0 while in WRITE with `avm_waitrequest` = 1. Required: on the next edge `avm_write` = 0, `busy` = 0, and all outputs are 0; no `data_sent` pulse.
